// File: rtl/top_level.sv
`default_nettype none
// ============================================================================
// Module   : top_level
// Desc     : LED-panel driver model. Serialises rA..rD MSB-first into four
//            time-multiplexed 32-bit shift/latch devices (16 byte outputs).
//            Macro LED_PERSIST_EN: every device always drives its own storage.
// Revision : 1.0 - initial release
// ============================================================================
module top_level #(
  parameter int WIDTH       = 32,
  parameter int NUM_DEV     = 4,
  parameter int SLOT_CYCLES = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rA,
  input  logic [WIDTH-1:0] rB,
  input  logic [WIDTH-1:0] rC,
  input  logic [WIDTH-1:0] rD,
  output logic [7:0]       out_A,
  output logic [7:0]       out_B,
  output logic [7:0]       out_C,
  output logic [7:0]       out_D,
  output logic [7:0]       out_E,
  output logic [7:0]       out_F,
  output logic [7:0]       out_G,
  output logic [7:0]       out_H,
  output logic [7:0]       out_I,
  output logic [7:0]       out_J,
  output logic [7:0]       out_K,
  output logic [7:0]       out_L,
  output logic [7:0]       out_M,
  output logic [7:0]       out_N,
  output logic [7:0]       out_O,
  output logic [7:0]       out_P
);

  localparam int c_SLOT_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int c_CYC_W  = $clog2(SLOT_CYCLES);

  localparam logic [c_CYC_W-1:0]  c_LAST_CYCLE  = c_CYC_W'(SLOT_CYCLES - 1);
  localparam logic [c_CYC_W-1:0]  c_SHIFT_LAST  = c_CYC_W'(WIDTH);
  localparam logic [c_CYC_W-1:0]  c_LATCH_CYCLE = c_CYC_W'(WIDTH + 1);
  localparam logic [c_SLOT_W-1:0] c_LAST_DEV    = c_SLOT_W'(NUM_DEV - 1);

  logic [c_SLOT_W-1:0] r_slot;
  logic [c_CYC_W-1:0]  r_cycle;
  logic [WIDTH-1:0]    r_ser;
  logic [WIDTH-1:0]    r_chain [NUM_DEV];
  logic [WIDTH-1:0]    r_store [NUM_DEV];
  logic [c_SLOT_W-1:0] r_active;
  logic                r_active_valid;

  logic [WIDTH-1:0]    w_word    [NUM_DEV];
  logic [WIDTH-1:0]    w_dev_out [NUM_DEV];
  logic                w_shift;

  assign w_word[0] = rA;
  assign w_word[1] = rB;
  assign w_word[2] = rC;
  assign w_word[3] = rD;

  assign w_shift = (r_cycle != '0) && (r_cycle <= c_SHIFT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot         <= '0;
      r_cycle        <= '0;
      r_ser          <= '0;
      r_active       <= '0;
      r_active_valid <= 1'b0;
      for (int k = 0; k < NUM_DEV; k++) begin
        r_chain[k] <= '0;
        r_store[k] <= '0;
      end
    end else begin
      if (r_cycle == c_LAST_CYCLE) begin
        r_cycle <= '0;
        r_slot  <= (r_slot == c_LAST_DEV) ? '0 : r_slot + c_SLOT_W'(1);
      end else begin
        r_cycle <= r_cycle + c_CYC_W'(1);
      end

      // Only the chain owned by the current slot moves; the rest hold.
      if (r_cycle == '0) begin
        r_ser <= w_word[r_slot];
      end else if (w_shift) begin
        r_ser           <= r_ser << 1;
        r_chain[r_slot] <= {r_chain[r_slot][WIDTH-2:0], r_ser[WIDTH-1]};
      end else if (r_cycle == c_LATCH_CYCLE) begin
        r_store[r_slot] <= r_chain[r_slot];
        r_active        <= r_slot;
        r_active_valid  <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_DEV; k++) begin : g_dev
    logic w_on;
`ifdef LED_PERSIST_EN
    assign w_on = 1'b1;
`else
    assign w_on = r_active_valid && (r_active == c_SLOT_W'(k));
`endif
    assign w_dev_out[k] = w_on ? r_store[k] : '0;
  end

  assign {out_D, out_C, out_B, out_A} = w_dev_out[0];
  assign {out_H, out_G, out_F, out_E} = w_dev_out[1];
  assign {out_L, out_K, out_J, out_I} = w_dev_out[2];
  assign {out_P, out_O, out_N, out_M} = w_dev_out[3];

endmodule
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_level
// Desc     : Scoreboard bench for top_level; honours LED_PERSIST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_level;

  logic        clk;
  logic        rst;
  logic [31:0] rA, rB, rC, rD;
  logic [7:0]  out_A, out_B, out_C, out_D, out_E, out_F, out_G, out_H;
  logic [7:0]  out_I, out_J, out_K, out_L, out_M, out_N, out_O, out_P;

  int checks;
  int failures;

  typedef struct {
    int           edge_no;
    logic [127:0] val;
    string        name;
  } exp_t;

  exp_t sb[$];

  top_level dut (
    .clk(clk), .rst(rst),
    .rA(rA), .rB(rB), .rC(rC), .rD(rD),
    .out_A(out_A), .out_B(out_B), .out_C(out_C), .out_D(out_D),
    .out_E(out_E), .out_F(out_F), .out_G(out_G), .out_H(out_H),
    .out_I(out_I), .out_J(out_J), .out_K(out_K), .out_L(out_L),
    .out_M(out_M), .out_N(out_N), .out_O(out_O), .out_P(out_P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device k occupies bits [32k +: 32] of the flattened output bus.
  function automatic logic [127:0] get_outs();
    return {out_P, out_O, out_N, out_M, out_L, out_K, out_J, out_I,
            out_H, out_G, out_F, out_E, out_D, out_C, out_B, out_A};
  endfunction

  // Panel view after device `dev` latches `w`, given the previous view.
  function automatic logic [127:0] next_view(input logic [127:0] prev,
                                             input int dev,
                                             input logic [31:0] w);
    logic [127:0] v;
`ifdef LED_PERSIST_EN
    v = prev;
`else
    v = '0;
    if (prev == '0) v = '0;
`endif
    v[dev*32 +: 32] = w;
    return v;
  endfunction

  function automatic void push(input int e, input logic [127:0] v, input string n);
    exp_t x;
    x.edge_no = e;
    x.val     = v;
    x.name    = n;
    sb.push_back(x);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    rA = 32'hB; rB = 32'hB; rC = 32'hB; rD = 32'hB;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (get_outs() !== 128'h0) begin
      failures++;
      $display("FAIL reset_hold actual=%h required=%h", get_outs(), 128'h0);
    end
    rst = 1'b0;
    push(1, '0, "reset_first_edge");
    @(posedge clk); #1;
    x = sb.pop_front();
    checks++;
    if (get_outs() !== x.val) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", x.name, get_outs(), x.val);
    end
  endtask

  task automatic test_basic();
    exp_t x;
    logic [127:0] v0, v1;
    rA = 32'hB; rB = 32'hB; rC = 32'hB; rD = 32'hB;
    do_reset();
    v0 = next_view('0, 0, 32'hB);
    v1 = next_view(v0, 1, 32'hB);
    push(33, '0, "basic_before_latch");
    push(34, v0, "basic_dev0_on");
    push(70, v0, "basic_dev0_hold");
    push(71, v1, "basic_dev1_on");
    for (int e = 1; e <= 71; e++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].edge_no == e) begin
        x = sb.pop_front();
        checks++;
        if (get_outs() !== x.val) begin
          failures++;
          $display("FAIL %s edge=%0d actual=%h required=%h", x.name, e, get_outs(), x.val);
        end
      end
    end
  endtask

  task automatic test_patterns();
    exp_t x;
    logic [127:0] v;
    logic [31:0]  w [4];
    w[0] = 32'h80000001; w[1] = 32'hA5C30FF0; w[2] = 32'hFFFFFFFF; w[3] = 32'h12345678;
    rA = w[0]; rB = w[1]; rC = w[2]; rD = w[3];
    do_reset();
    v = '0;
    for (int j = 0; j < 6; j++) begin
      v = next_view(v, j % 4, w[j % 4]);
      push(34 + 37 * j, v, $sformatf("pattern_slot%0d", j));
      if (j == 3) push(181, v, "pattern_dev3_hold");
    end
    for (int e = 1; e <= 219; e++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].edge_no == e) begin
        x = sb.pop_front();
        checks++;
        if (get_outs() !== x.val) begin
          failures++;
          $display("FAIL %s edge=%0d actual=%h required=%h", x.name, e, get_outs(), x.val);
        end
      end
    end
  endtask

  task automatic test_input_change();
    exp_t x;
    logic [127:0] v;
    rA = 32'h11111111; rB = 32'h22222222; rC = 32'h33333333; rD = 32'h44444444;
    do_reset();
    v = next_view('0, 0, 32'h11111111);
    push(34, v, "change_old_latched");
    v = next_view(v, 1, 32'h22222222);
    v = next_view(v, 2, 32'h33333333);
    v = next_view(v, 3, 32'h44444444);
    push(145, v, "change_dev3");
    v = next_view(v, 0, 32'hDEADBEEF);
    push(182, v, "change_new_latched");
    for (int e = 1; e <= 182; e++) begin
      @(posedge clk); #1;
      if (e == 6) rA = 32'hDEADBEEF;
      if (sb.size() != 0 && sb[0].edge_no == e) begin
        x = sb.pop_front();
        checks++;
        if (get_outs() !== x.val) begin
          failures++;
          $display("FAIL %s edge=%0d actual=%h required=%h", x.name, e, get_outs(), x.val);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    logic [127:0] v;
    rA = 32'hCAFEF00D; rB = 32'h0BADBEEF; rC = 32'h5A5A5A5A; rD = 32'h0;
    do_reset();
    v = next_view('0, 0, 32'hCAFEF00D);
    push(34, v, "mid_dev0_before_reset");
    push(58, '0, "mid_reset_edge");
    for (int e = 1; e <= 58; e++) begin
      @(posedge clk); #1;
      if (e == 57) rst = 1'b1;
      if (sb.size() != 0 && sb[0].edge_no == e) begin
        x = sb.pop_front();
        checks++;
        if (get_outs() !== x.val) begin
          failures++;
          $display("FAIL %s edge=%0d actual=%h required=%h", x.name, e, get_outs(), x.val);
        end
      end
    end
    rst = 1'b0;
    push(33, '0, "mid_restart_before_latch");
    push(34, v, "mid_restart_dev0");
    v = next_view(v, 1, 32'h0BADBEEF);
    push(71, v, "mid_restart_dev1");
    for (int e = 1; e <= 71; e++) begin
      @(posedge clk); #1;
      if (sb.size() != 0 && sb[0].edge_no == e) begin
        x = sb.pop_front();
        checks++;
        if (get_outs() !== x.val) begin
          failures++;
          $display("FAIL %s edge=%0d actual=%h required=%h", x.name, e, get_outs(), x.val);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    rA = '0; rB = '0; rC = '0; rD = '0;
    test_reset();
    test_basic();
    test_patterns();
    test_input_change();
    test_reset_mid();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
